// File: rtl/pcs_scrambler_core.sv
// Self-synchronising 64b/66b (de)scrambler, G(x)=1+x^39+x^58, with a 2-entry skid buffer.
// Optional seed-load ports are compiled in when PCS_SCR_SEED_LOAD_EN is defined.
module pcs_scrambler_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MODE       = 0,
  parameter logic [57:0] LFSR_INIT  = {58{1'b1}}
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
`ifdef PCS_SCR_SEED_LOAD_EN
  input  logic                  i_seed_load,
  input  logic [57:0]           i_seed,
`endif
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_hdr,
  input  logic                  i_hdr_valid,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_hdr,
  output logic                  o_hdr_valid
);

  // Occupancy of output register + skid entry
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  buf_state_e            state_q, state_d;
  logic [57:0]           lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            out_hdr_q, out_hdr_d;
  logic                  out_hdr_valid_q, out_hdr_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [1:0]            skid_hdr_q, skid_hdr_d;
  logic                  skid_hdr_valid_q, skid_hdr_valid_d;

  logic [57:0]           lfsr_post;
  logic [DATA_WIDTH-1:0] scr_data;
  logic                  fb;
  logic                  accept;
  logic                  emit;
  logic                  seed_load;

`ifdef PCS_SCR_SEED_LOAD_EN
  assign seed_load = i_seed_load;
`else
  assign seed_load = 1'b0;
`endif

  assign o_valid     = (state_q != BUF_EMPTY);
  assign o_ready     = (state_q != BUF_FULL) && !seed_load;
  assign accept      = i_valid && o_ready;
  assign emit        = o_valid && i_ready;
  assign o_data      = out_data_q;
  assign o_hdr       = out_hdr_q;
  assign o_hdr_valid = out_hdr_valid_q;

  // Bit-serial LFSR unrolled across the beat; bit 0 goes first on the line
  always_comb begin
    lfsr_post = lfsr_q;
    scr_data  = '0;
    fb        = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      fb          = lfsr_post[38] ^ lfsr_post[57];
      scr_data[i] = i_data[i] ^ fb;
      lfsr_post   = {lfsr_post[56:0], (MODE == 1) ? i_data[i] : scr_data[i]};
    end
  end

  always_comb begin
    state_d          = state_q;
    lfsr_d           = lfsr_q;
    out_data_d       = out_data_q;
    out_hdr_d        = out_hdr_q;
    out_hdr_valid_d  = out_hdr_valid_q;
    skid_data_d      = skid_data_q;
    skid_hdr_d       = skid_hdr_q;
    skid_hdr_valid_d = skid_hdr_valid_q;

    if (seed_load) begin
`ifdef PCS_SCR_SEED_LOAD_EN
      lfsr_d = i_seed;
`endif
    end else if (accept) begin
      lfsr_d = lfsr_post;
    end

    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          out_data_d      = scr_data;
          out_hdr_d       = i_hdr;
          out_hdr_valid_d = i_hdr_valid;
          state_d         = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && emit) begin
          out_data_d      = scr_data;
          out_hdr_d       = i_hdr;
          out_hdr_valid_d = i_hdr_valid;
        end else if (accept) begin
          skid_data_d      = scr_data;
          skid_hdr_d       = i_hdr;
          skid_hdr_valid_d = i_hdr_valid;
          state_d          = BUF_FULL;
        end else if (emit) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (emit) begin
          out_data_d      = skid_data_q;
          out_hdr_d       = skid_hdr_q;
          out_hdr_valid_d = skid_hdr_valid_q;
          state_d         = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q          <= BUF_EMPTY;
      lfsr_q           <= LFSR_INIT;
      out_data_q       <= '0;
      out_hdr_q        <= '0;
      out_hdr_valid_q  <= 1'b0;
      skid_data_q      <= '0;
      skid_hdr_q       <= '0;
      skid_hdr_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      lfsr_q           <= lfsr_d;
      out_data_q       <= out_data_d;
      out_hdr_q        <= out_hdr_d;
      out_hdr_valid_q  <= out_hdr_valid_d;
      skid_data_q      <= skid_data_d;
      skid_hdr_q       <= skid_hdr_d;
      skid_hdr_valid_q <= skid_hdr_valid_d;
    end
  end

endmodule
